// File: rtl/lvds_rx_link_monitor.sv
// Lock/unlock state machine for one 8b10b LVDS receive lane; pulses the receiver reset on loss of lock or frame timeout.
// Outputs are one cycle behind the sampled strobe; frame/error counters exist only with LVDS_RX_MON_COUNTERS_EN defined.
`timescale 1ns/1ps
module lvds_rx_link_monitor #(
   parameter int LOCK_FRAMES    = 8,
   parameter int UNLOCK_ERRORS  = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int RESET_CYCLES   = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_data_rdy,
   input  logic                 i_code_err,
   input  logic                 i_disp_err,
   input  logic                 i_sync_err,
   input  logic                 i_clear_counts,
   output logic                 o_rx_reset,
   output logic                 o_locked,
   output logic                 o_link_lost,
   output logic [1:0]           o_state,
   output logic [CNT_WIDTH-1:0] o_frame_count,
   output logic [CNT_WIDTH-1:0] o_err_count
);

   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam int UW = $clog2(UNLOCK_ERRORS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t         state;
   logic [RW-1:0]  rst_cnt;
   logic [GW-1:0]  good_cnt;
   logic [UW-1:0]  bad_cnt;
   logic [TW-1:0]  to_cnt;
   logic           link_lost;

   logic any_err;
   logic good_frame;
   logic bad_frame;
   logic timeout;

   assign any_err    = i_code_err | i_disp_err | i_sync_err;
   assign good_frame = i_data_rdy & ~any_err;
   assign bad_frame  = i_data_rdy &  any_err;
   // A frame landing on the timeout cycle takes precedence over the timeout.
   assign timeout    = (to_cnt == TW'(TIMEOUT_CYCLES - 1)) & ~i_data_rdy;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_RESET;
         rst_cnt   <= '0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
         to_cnt    <= '0;
         link_lost <= 1'b0;
      end else begin
         link_lost <= 1'b0;
         case (state)
            ST_RESET: begin
               to_cnt   <= '0;
               good_cnt <= '0;
               bad_cnt  <= '0;
               if (rst_cnt == RW'(RESET_CYCLES - 1)) begin
                  state   <= ST_HUNT;
                  rst_cnt <= '0;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            ST_HUNT: begin
               if (good_frame) begin
                  to_cnt <= '0;
                  if (good_cnt == GW'(LOCK_FRAMES - 1)) begin
                     state    <= ST_LOCKED;
                     good_cnt <= '0;
                     bad_cnt  <= '0;
                  end else begin
                     good_cnt <= good_cnt + 1'b1;
                  end
               end else if (bad_frame) begin
                  to_cnt   <= '0;
                  good_cnt <= '0;
               end else if (timeout) begin
                  state   <= ST_RESET;
                  rst_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_LOCKED: begin
               if (bad_frame) begin
                  to_cnt <= '0;
                  if (bad_cnt == UW'(UNLOCK_ERRORS - 1)) begin
                     state     <= ST_RESET;
                     rst_cnt   <= '0;
                     link_lost <= 1'b1;
                  end else begin
                     bad_cnt <= bad_cnt + 1'b1;
                  end
               end else if (good_frame) begin
                  to_cnt  <= '0;
                  bad_cnt <= '0;
               end else if (timeout) begin
                  state     <= ST_RESET;
                  rst_cnt   <= '0;
                  link_lost <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               state   <= ST_RESET;
               rst_cnt <= '0;
            end
         endcase
      end
   end

   assign o_rx_reset  = (state == ST_RESET);
   assign o_locked    = (state == ST_LOCKED);
   assign o_state     = state;
   assign o_link_lost = link_lost;

`ifdef LVDS_RX_MON_COUNTERS_EN
   logic [CNT_WIDTH-1:0] frame_cnt;
   logic [CNT_WIDTH-1:0] err_cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else if (i_clear_counts) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else if (i_data_rdy && state != ST_RESET) begin
         if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
         if (any_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
   end

   assign o_frame_count = frame_cnt;
   assign o_err_count   = err_cnt;
`else
   logic unused_clear;
   assign unused_clear  = i_clear_counts;
   assign o_frame_count = '0;
   assign o_err_count   = '0;
`endif

endmodule

// File: tb/tb_lvds_rx_link_monitor.sv
// Directed bench for lvds_rx_link_monitor: lock/unlock, timeouts, counter saturation and mid-run reset.
`timescale 1ns/1ps
module tb_lvds_rx_link_monitor;

   logic       i_clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       i_data_rdy = 1'b0;
   logic       i_code_err = 1'b0;
   logic       i_disp_err = 1'b0;
   logic       i_sync_err = 1'b0;
   logic       i_clear_counts = 1'b0;
   logic       o_rx_reset;
   logic       o_locked;
   logic       o_link_lost;
   logic [1:0] o_state;
   logic [3:0] o_frame_count;
   logic [3:0] o_err_count;

   int checks = 0;
   int errors = 0;

`ifdef LVDS_RX_MON_COUNTERS_EN
   localparam bit CE = 1'b1;
`else
   localparam bit CE = 1'b0;
`endif

   always #5 i_clk = ~i_clk;

   lvds_rx_link_monitor #(
      .LOCK_FRAMES(8), .UNLOCK_ERRORS(4), .TIMEOUT_CYCLES(1024),
      .RESET_CYCLES(16), .CNT_WIDTH(4)
   ) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_data_rdy(i_data_rdy),
      .i_code_err(i_code_err), .i_disp_err(i_disp_err), .i_sync_err(i_sync_err),
      .i_clear_counts(i_clear_counts), .o_rx_reset(o_rx_reset), .o_locked(o_locked),
      .o_link_lost(o_link_lost), .o_state(o_state),
      .o_frame_count(o_frame_count), .o_err_count(o_err_count)
   );

   // Counter outputs read zero when the counters are not built.
   function automatic logic [3:0] exp_cnt(input int v);
      return CE ? 4'(v) : 4'd0;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic strobe(input logic c, input logic d, input logic s);
      i_data_rdy = 1'b1; i_code_err = c; i_disp_err = d; i_sync_err = s;
      tick();
      i_data_rdy = 1'b0; i_code_err = 1'b0; i_disp_err = 1'b0; i_sync_err = 1'b0;
   endtask

   task automatic test_reset();
      idle(3);
      checks++; if (o_rx_reset !== 1'b1) begin errors++; $display("FAIL rst_rx_reset got %0b exp 1", o_rx_reset); end
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", o_state); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %0b exp 0", o_locked); end
      checks++; if (o_link_lost !== 1'b0) begin errors++; $display("FAIL rst_link_lost got %0b exp 0", o_link_lost); end
      checks++; if (o_frame_count !== 4'd0) begin errors++; $display("FAIL rst_frame_count got %0d exp 0", o_frame_count); end
      checks++; if (o_err_count !== 4'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", o_err_count); end
      i_reset_n = 1'b1;
      idle(15);
      checks++; if (o_rx_reset !== 1'b1) begin errors++; $display("FAIL rst_pulse_15 got %0b exp 1", o_rx_reset); end
      tick();
      checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL rst_hunt_16 got %0d exp 1", o_state); end
      checks++; if (o_rx_reset !== 1'b0) begin errors++; $display("FAIL rst_release got %0b exp 0", o_rx_reset); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL rst_hunt_locked got %0b exp 0", o_locked); end
   endtask

   task automatic test_lock();
      for (int i = 0; i < 8; i++) begin
         strobe(1'b0, 1'b0, 1'b0);
         if (i == 6) begin
            checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL lock_early got %0b exp 0", o_locked); end
         end
         if (i < 7) idle(11);
      end
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL lock_rise got %0b exp 1", o_locked); end
      checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL lock_state got %0d exp 2", o_state); end
      checks++; if (o_frame_count !== exp_cnt(8)) begin errors++; $display("FAIL lock_frames got %0d exp %0d", o_frame_count, exp_cnt(8)); end
      checks++; if (o_err_count !== exp_cnt(0)) begin errors++; $display("FAIL lock_errs got %0d exp %0d", o_err_count, exp_cnt(0)); end
   endtask

   task automatic test_unlock();
      i_clear_counts = 1'b1; tick(); i_clear_counts = 1'b0;
      strobe(1'b1, 1'b0, 1'b0); idle(2);
      strobe(1'b0, 1'b1, 1'b0); idle(2);
      strobe(1'b0, 1'b0, 1'b1); idle(2);
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL unlock_run1 got %0b exp 1", o_locked); end
      strobe(1'b0, 1'b0, 1'b0); idle(2);
      strobe(1'b1, 1'b0, 1'b0); idle(2);
      strobe(1'b0, 1'b1, 1'b0); idle(2);
      strobe(1'b0, 1'b0, 1'b1); idle(2);
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL unlock_run2_3 got %0b exp 1", o_locked); end
      strobe(1'b1, 1'b0, 1'b0);
      checks++; if (o_link_lost !== 1'b1) begin errors++; $display("FAIL unlock_lost got %0b exp 1", o_link_lost); end
      checks++; if (o_rx_reset !== 1'b1) begin errors++; $display("FAIL unlock_rx_reset got %0b exp 1", o_rx_reset); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL unlock_locked got %0b exp 0", o_locked); end
      checks++; if (o_err_count !== exp_cnt(7)) begin errors++; $display("FAIL unlock_errs got %0d exp %0d", o_err_count, exp_cnt(7)); end
      checks++; if (o_frame_count !== exp_cnt(8)) begin errors++; $display("FAIL unlock_frames got %0d exp %0d", o_frame_count, exp_cnt(8)); end
      tick();
      checks++; if (o_link_lost !== 1'b0) begin errors++; $display("FAIL unlock_lost_width got %0b exp 0", o_link_lost); end
      idle(14);
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL unlock_pulse got %0d exp 0", o_state); end
      tick();
      checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL unlock_rehunt got %0d exp 1", o_state); end
   endtask

   task automatic test_no_premature();
      for (int i = 0; i < 7; i++) begin strobe(1'b0, 1'b0, 1'b0); idle(2); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL nopre_7good got %0b exp 0", o_locked); end
      strobe(1'b0, 1'b0, 1'b1); idle(2);
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL nopre_bad got %0b exp 0", o_locked); end
      for (int i = 0; i < 7; i++) begin strobe(1'b0, 1'b0, 1'b0); idle(2); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL nopre_15good got %0b exp 0", o_locked); end
      strobe(1'b0, 1'b0, 1'b0);
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL nopre_final got %0b exp 1", o_locked); end
   endtask

   task automatic test_timeout();
      idle(1023);
      checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL to_1023 got %0d exp 2", o_state); end
      tick();
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL to_1024 got %0d exp 0", o_state); end
      checks++; if (o_link_lost !== 1'b1) begin errors++; $display("FAIL to_lost got %0b exp 1", o_link_lost); end
      idle(16);
      for (int i = 0; i < 8; i++) strobe(1'b0, 1'b0, 1'b0);
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL to_relock got %0b exp 1", o_locked); end
      idle(1023);
      strobe(1'b0, 1'b0, 1'b0);
      checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL to_coincide got %0d exp 2", o_state); end
      checks++; if (o_link_lost !== 1'b0) begin errors++; $display("FAIL to_coincide_lost got %0b exp 0", o_link_lost); end
      idle(1023);
      checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL to_restart got %0d exp 2", o_state); end
      tick();
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL to_second got %0d exp 0", o_state); end
      idle(16);
   endtask

   task automatic test_counters();
      i_clear_counts = 1'b1; tick(); i_clear_counts = 1'b0;
      for (int i = 0; i < 20; i++) begin
         strobe(1'b0, 1'b1, 1'b0);
         if (i == 14) begin
            checks++; if (o_frame_count !== exp_cnt(15)) begin errors++; $display("FAIL cnt_reach got %0d exp %0d", o_frame_count, exp_cnt(15)); end
         end
      end
      checks++; if (o_frame_count !== exp_cnt(15)) begin errors++; $display("FAIL cnt_frame_sat got %0d exp %0d", o_frame_count, exp_cnt(15)); end
      checks++; if (o_err_count !== exp_cnt(15)) begin errors++; $display("FAIL cnt_err_sat got %0d exp %0d", o_err_count, exp_cnt(15)); end
      checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL cnt_hunt_bad got %0d exp 1", o_state); end
      i_clear_counts = 1'b1;
      strobe(1'b1, 1'b0, 1'b0);
      i_clear_counts = 1'b0;
      checks++; if (o_frame_count !== 4'd0) begin errors++; $display("FAIL cnt_clr_frame got %0d exp 0", o_frame_count); end
      checks++; if (o_err_count !== 4'd0) begin errors++; $display("FAIL cnt_clr_err got %0d exp 0", o_err_count); end
      strobe(1'b0, 1'b0, 1'b0);
      checks++; if (o_frame_count !== exp_cnt(1)) begin errors++; $display("FAIL cnt_after_clr got %0d exp %0d", o_frame_count, exp_cnt(1)); end
   endtask

   task automatic test_hunt_timeout();
      idle(1023);
      checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL hto_1023 got %0d exp 1", o_state); end
      tick();
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL hto_1024 got %0d exp 0", o_state); end
      checks++; if (o_link_lost !== 1'b0) begin errors++; $display("FAIL hto_no_lost got %0b exp 0", o_link_lost); end
      strobe(1'b1, 1'b0, 1'b0);
      checks++; if (o_frame_count !== exp_cnt(1)) begin errors++; $display("FAIL hto_rst_frame got %0d exp %0d", o_frame_count, exp_cnt(1)); end
      checks++; if (o_err_count !== 4'd0) begin errors++; $display("FAIL hto_rst_err got %0d exp 0", o_err_count); end
      idle(14);
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL hto_pulse got %0d exp 0", o_state); end
      tick();
      checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL hto_rehunt got %0d exp 1", o_state); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 8; i++) strobe(1'b0, 1'b0, 1'b0);
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL arst_prelock got %0b exp 1", o_locked); end
      #2 i_reset_n = 1'b0;
      #1;
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL arst_state got %0d exp 0", o_state); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL arst_locked got %0b exp 0", o_locked); end
      checks++; if (o_rx_reset !== 1'b1) begin errors++; $display("FAIL arst_rx_reset got %0b exp 1", o_rx_reset); end
      checks++; if (o_link_lost !== 1'b0) begin errors++; $display("FAIL arst_lost got %0b exp 0", o_link_lost); end
      checks++; if (o_frame_count !== 4'd0) begin errors++; $display("FAIL arst_frame got %0d exp 0", o_frame_count); end
      idle(2);
      i_reset_n = 1'b1;
      idle(15);
      checks++; if (o_rx_reset !== 1'b1) begin errors++; $display("FAIL arst_pulse got %0b exp 1", o_rx_reset); end
      tick();
      checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL arst_hunt got %0d exp 1", o_state); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_unlock();
      test_no_premature();
      test_timeout();
      test_counters();
      test_hunt_timeout();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
